// File: rtl/sap_register_bank.sv
// General-purpose register bank for the 16-bit SAP datapath: addressable registers with
// LOAD/INC/DEC/CLR commands, two combinational read ports and a full-bank shadow copy.
module sap_register_bank #(
  parameter int unsigned           WIDTH     = 16,
  parameter int unsigned           NUM_REGS  = 4,
  parameter int unsigned           ADDR_W    = 2,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [WIDTH-1:0]  bus,
  input  logic              save,
  input  logic              restore,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_a,
  output logic [WIDTH-1:0]  rd_b,
  output logic              zero_a,
  output logic              wrap,
  output logic              addr_err
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  localparam logic [ADDR_W:0] NUM_REGS_W = NUM_REGS[ADDR_W:0];

  logic [WIDTH-1:0] r_regs     [NUM_REGS];
  logic [WIDTH-1:0] r_shadow   [NUM_REGS];
  logic [WIDTH-1:0] w_regs_d   [NUM_REGS];
  logic [WIDTH-1:0] w_shadow_d [NUM_REGS];
  logic             r_wrap;
  logic             r_addr_err;

  logic             w_addr_ok;
  logic             w_cmd_en;
  logic             w_cmd_ok;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_result;
  logic             w_wrap_d;
  logic             w_addr_err_d;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  // Read ports decode by comparison so unpopulated indices fall through to zero.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    w_cur  = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (rd_addr_a == ADDR_W'(i)) w_rd_a = r_regs[i];
      if (rd_addr_b == ADDR_W'(i)) w_rd_b = r_regs[i];
      if (cmd_addr == ADDR_W'(i))  w_cur  = r_regs[i];
    end
  end

  assign rd_a   = w_rd_a;
  assign rd_b   = w_rd_b;
  assign zero_a = (w_rd_a == '0);

  // Restore (alone or as part of a swap) pre-empts any command.
  assign w_addr_ok = ({1'b0, cmd_addr} < NUM_REGS_W);
  assign w_cmd_en  = cmd_valid & ~restore;
  assign w_cmd_ok  = w_cmd_en & w_addr_ok;

  always_comb begin
    w_result = w_cur;
    unique case (cmd_op)
      OP_LOAD: w_result = bus;
      OP_INC:  w_result = w_cur + WIDTH'(1);
      OP_DEC:  w_result = w_cur - WIDTH'(1);
      OP_CLR:  w_result = '0;
      default: w_result = w_cur;
    endcase
  end

  always_comb begin
    w_wrap_d = 1'b0;
    if (w_cmd_ok) begin
      if (cmd_op == OP_INC && (&w_cur))     w_wrap_d = 1'b1;
      if (cmd_op == OP_DEC && w_cur == '0)  w_wrap_d = 1'b1;
    end
  end

  assign w_addr_err_d = w_cmd_en & ~w_addr_ok;

  always_comb begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      w_regs_d[i]   = r_regs[i];
      w_shadow_d[i] = r_shadow[i];
      if (restore) begin
        w_regs_d[i] = r_shadow[i];
      end else if (w_cmd_ok && cmd_addr == ADDR_W'(i)) begin
        w_regs_d[i] = w_result;
      end
      // Shadow captures pre-edge registers, so a swap is atomic.
      if (save) begin
        w_shadow_d[i] = r_regs[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i]   <= RESET_VAL;
        r_shadow[i] <= RESET_VAL;
      end
      r_wrap     <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        r_regs[i]   <= w_regs_d[i];
        r_shadow[i] <= w_shadow_d[i];
      end
      r_wrap     <= w_wrap_d;
      r_addr_err <= w_addr_err_d;
    end
  end

  assign wrap     = r_wrap;
  assign addr_err = r_addr_err;

endmodule

// File: tb/tb_sap_register_bank.sv
// Bench for sap_register_bank (3-register build): directed steps plus randomized commands
// checked against an array-based reference model.
`timescale 1ns/1ps
module tb_sap_register_bank;

  localparam int NR = 3;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [1:0]  cmd_addr;
  logic [15:0] bus;
  logic        save;
  logic        restore;
  logic [1:0]  rd_addr_a;
  logic [1:0]  rd_addr_b;
  logic [15:0] rd_a;
  logic [15:0] rd_b;
  logic        zero_a;
  logic        wrap;
  logic        addr_err;

  sap_register_bank #(
    .WIDTH    (16),
    .NUM_REGS (NR),
    .ADDR_W   (2),
    .RESET_VAL(16'h0000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .bus      (bus),
    .save     (save),
    .restore  (restore),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_a     (rd_a),
    .rd_b     (rd_b),
    .zero_a   (zero_a),
    .wrap     (wrap),
    .addr_err (addr_err)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state
  int m_reg [NR];
  int m_sh  [NR];
  int m_wrap;
  int m_err;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_reg[i] = 0;
      m_sh[i]  = 0;
    end
    m_wrap = 0;
    m_err  = 0;
  endtask

  // Architectural effect of one clock edge with the given controls.
  task automatic model_edge(input int v, input int op, input int a, input int d,
                            input int sv, input int rs);
    int old_reg [NR];
    for (int i = 0; i < NR; i++) old_reg[i] = m_reg[i];
    m_wrap = 0;
    m_err  = 0;
    if (rs != 0) begin
      for (int i = 0; i < NR; i++) m_reg[i] = m_sh[i];
      if (sv != 0) for (int i = 0; i < NR; i++) m_sh[i] = old_reg[i];
    end else begin
      if (sv != 0) for (int i = 0; i < NR; i++) m_sh[i] = old_reg[i];
      if (v != 0) begin
        if (a >= NR) begin
          m_err = 1;
        end else begin
          case (op)
            0: m_reg[a] = d;
            1: begin
              m_wrap   = (old_reg[a] == 65535) ? 1 : 0;
              m_reg[a] = (old_reg[a] + 1) % 65536;
            end
            2: begin
              m_wrap   = (old_reg[a] == 0) ? 1 : 0;
              m_reg[a] = (old_reg[a] + 65535) % 65536;
            end
            default: m_reg[a] = 0;
          endcase
        end
      end
    end
  endtask

  // Sweeps every index (including the unpopulated one) on both ports.
  task automatic check_all(input string tag);
    for (int i = 0; i < 4; i++) begin
      int exp_a;
      int exp_b;
      int ib;
      ib = (i + 1) % 4;
      rd_addr_a = 2'(i);
      rd_addr_b = 2'(ib);
      #1;
      exp_a = (i < NR) ? m_reg[i] : 0;
      exp_b = (ib < NR) ? m_reg[ib] : 0;
      chk($sformatf("%s rd_a[%0d]", tag, i), int'(rd_a), exp_a);
      chk($sformatf("%s rd_b[%0d]", tag, ib), int'(rd_b), exp_b);
      chk($sformatf("%s zero_a[%0d]", tag, i), int'(zero_a), (exp_a == 0) ? 1 : 0);
    end
    chk({tag, " wrap"}, int'(wrap), m_wrap);
    chk({tag, " addr_err"}, int'(addr_err), m_err);
  endtask

  task automatic step(input string tag, input int v, input int op, input int a, input int d,
                      input int sv, input int rs);
    @(negedge clk);
    cmd_valid = v[0];
    cmd_op    = 2'(op);
    cmd_addr  = 2'(a);
    bus       = 16'(d);
    save      = sv[0];
    restore   = rs[0];
    @(posedge clk);
    model_edge(v, op, a, d, sv, rs);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 2'b00;
    bus       = 16'h0000;
    save      = 1'b0;
    restore   = 1'b0;
    rd_addr_a = 2'b00;
    rd_addr_b = 2'b00;
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;
    idle("post_reset");

    // LOAD then hold with cmd_valid low
    step("load_r1", 1, 0, 1, 'hBEEF, 0, 0);
    for (int k = 0; k < 5; k++) idle("hold_r1");

    // INC/DEC wrap-around
    step("load_r2", 1, 0, 2, 'hFFFF, 0, 0);
    step("inc_wrap", 1, 1, 2, 0, 0, 0);
    step("dec_wrap", 1, 2, 2, 0, 0, 0);
    idle("wrap_drop");
    step("load_r0_5", 1, 0, 0, 'h0005, 0, 0);
    step("inc_nowrap", 1, 1, 0, 0, 0, 0);

    // Save captures pre-edge values
    step("clr_r0", 1, 3, 0, 0, 0, 0);
    step("load_save", 1, 0, 0, 'h1234, 1, 0);
    step("restore_pre", 0, 0, 0, 0, 0, 1);
    step("load_r0_1234", 1, 0, 0, 'h1234, 0, 0);
    step("save", 0, 0, 0, 0, 1, 0);
    step("clr_r0b", 1, 3, 0, 0, 0, 0);
    step("restore", 0, 0, 0, 0, 0, 1);

    // Swap with a dropped LOAD
    step("load_2222", 1, 0, 0, 'h2222, 0, 0);
    step("save_2222", 0, 0, 0, 0, 1, 0);
    step("load_1111", 1, 0, 0, 'h1111, 0, 0);
    step("swap", 1, 0, 0, 'h9999, 1, 1);
    step("restore_sw", 0, 0, 0, 0, 0, 1);
    step("restore_inc", 1, 1, 1, 0, 0, 1);

    // Out-of-range command
    step("bad_addr", 1, 0, 3, 'hAAAA, 0, 0);
    idle("bad_drop");
    step("bad_restore", 1, 1, 3, 0, 0, 1);

    // Reset during a command cycle
    step("preload", 1, 0, 1, 'h5A5A, 0, 0);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_addr  = 2'd2;
    bus       = 16'h7777;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("mid_reset");
    @(negedge clk);
    cmd_valid = 1'b0;
    rst       = 1'b0;
    idle("after_reset");

    // Randomized traffic, biased toward wrap boundaries
    for (int k = 0; k < 300; k++) begin
      int d;
      int sel;
      sel = int'($urandom_range(0, 3));
      d   = (sel == 0) ? 0 : (sel == 1) ? 'hFFFF : int'($urandom_range(0, 65535));
      step("rand", int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), d, int'($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sap_register_bank.md
Name: sap_register_bank

Overview:
Parametrised general-purpose register bank for the 16-bit SAP datapath. It generalises the single bus-loaded operand register into NUM_REGS addressable registers. Each register supports load-from-bus, increment, decrement and clear commands. A full-bank shadow copy supports save, restore and swap for interrupt/subroutine context. It sits on the shared bus beside the ALU; the two read ports feed the ALU operands.

Parameters:
WIDTH, 16, data width of every register and of bus.
NUM_REGS, 4, number of architectural registers, 2..16.
ADDR_W, 2, address width; must satisfy 2**ADDR_W >= NUM_REGS.
RESET_VAL, 0, value loaded into every register and every shadow entry on reset.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
cmd_valid  input  1  apply cmd_op to register cmd_addr this cycle
cmd_op  input  2  00 LOAD(bus), 01 INC, 10 DEC, 11 CLR
cmd_addr  input  ADDR_W  target register index
bus  input  WIDTH  shared bus data, used by LOAD only
save  input  1  copy all registers into the shadow bank
restore  input  1  copy the shadow bank into all registers
rd_addr_a  input  ADDR_W  read port A index
rd_addr_b  input  ADDR_W  read port B index
rd_a  output  WIDTH  contents of register rd_addr_a (combinational)
rd_b  output  WIDTH  contents of register rd_addr_b (combinational)
zero_a  output  1  rd_a == 0 (combinational)
wrap  output  1  registered 1-cycle pulse: last INC overflowed or last DEC underflowed
addr_err  output  1  registered 1-cycle pulse: last cmd_valid carried cmd_addr >= NUM_REGS

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - all registers and shadow entries = RESET_VAL;
  - wrap = 0, addr_err = 0;
  - rd_a/rd_b show RESET_VAL for in-range addresses.
- Read ports:
  - purely combinational from current register state; no write-through;
  - a value written at edge N appears on rd_a/rd_b after edge N;
  - out-of-range rd_addr returns 0 (zero_a = 1 for port A).
- Command (cmd_valid=1, cmd_addr in range), result visible after the next rising edge:
  - LOAD: reg <= bus;
  - INC: reg <= reg+1 modulo 2**WIDTH; wrap pulses if old value was all ones;
  - DEC: reg <= reg-1 modulo 2**WIDTH; wrap pulses if old value was 0;
  - CLR: reg <= 0;
  - other registers hold.
- cmd_valid=0: every register holds; wrap and addr_err drop to 0 the next cycle.
- Out-of-range cmd_addr: no register changes; addr_err = 1 for exactly one cycle; wrap = 0.
- save=1, restore=0:
  - shadow[i] <= reg[i] for all i, using pre-edge values (the same cycle's command is not included);
  - the command still applies to the registers.
- restore=1, save=0:
  - reg[i] <= shadow[i] for all i;
  - a simultaneous command is dropped (restore has priority); wrap and addr_err stay 0.
- save=1 and restore=1: swap, i.e. reg[i] <= shadow[i] and shadow[i] <= reg[i] atomically; any command is dropped.
- wrap and addr_err are never both 1.
- Reset asserted mid-sequence: all pending effects are discarded. The first edge after deassertion behaves from the reset state.

Test Plan:
- Reset, then read every index on both ports -> all 0x0000, zero_a=1, wrap=0, addr_err=0; out-of-range rd_addr (NUM_REGS=3 build, index 3) -> rd_a=0.
- LOAD r1 with 0xBEEF, then read A=r1 and B=r0 in the following cycle -> rd_a=0xBEEF, rd_b=0x0000; r1 unchanged when cmd_valid is low for 5 cycles.
- LOAD r2=0xFFFF, then INC r2 -> r2=0x0000 and wrap=1 for one cycle; then DEC r2 -> r2=0xFFFF and wrap=1; INC of 0x0005 -> 0x0006 with wrap=0.
- LOAD r0=0x1234 and save in the same cycle -> shadow r0=0x0000 (pre-edge value); save again, CLR r0, then restore -> r0=0x1234.
- With r0=0x1111 and shadow r0=0x2222, assert save+restore together with LOAD r0=0x9999 -> r0=0x2222, shadow r0=0x1111, the LOAD is dropped and no flags are raised.
- cmd_valid with cmd_addr=3 on a NUM_REGS=3 build -> addr_err pulses one cycle and no register changes. Also assert rst during a command cycle -> all registers read 0x0000 immediately.
